// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// func3 encodings, FSM states and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return is_signed_a(op) && (op != OP_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational iteration: BITS_PER_CYCLE shift-add multiply steps or
// restoring-division steps on a shared {high, low} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_out
);

  logic [BITS_PER_CYCLE:0][2*XLEN-1:0] chain;

  assign chain[0] = acc_in;

  // Multiply: high half accumulates, low half shifts the multiplier out.
  // Divide: high half is the partial remainder, low half shifts quotient in.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_w;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] mul_nxt;
    logic [2*XLEN-1:0] div_nxt;

    assign sum     = {1'b0, chain[i][2*XLEN-1:XLEN]} + (chain[i][0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {sum, chain[i][XLEN-1:1]};
    assign rem_w   = {chain[i][2*XLEN-1:XLEN], chain[i][XLEN-1]};
    assign diff    = rem_w - {1'b0, opnd};
    assign div_nxt = (rem_w >= {1'b0, opnd}) ?
                     {diff[XLEN-1:0], chain[i][XLEN-2:0], 1'b1} :
                     {rem_w[XLEN-1:0], chain[i][XLEN-2:0], 1'b0};
    assign chain[i+1] = div_mode ? div_nxt : mul_nxt;
  end

  assign acc_out = chain[BITS_PER_CYCLE];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: magnitudes are processed by muldiv_step,
// then sign-corrected; divide-by-zero and signed overflow finish immediately.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0]   opnd, a_mag, b_mag, special_res, div_raw, calc_res;
  logic [2:0]        op_q;
  logic              neg_q, a_neg, b_neg, div_zero, div_ovf, special, launch_neg;
  logic              launch;

  assign launch = (state == IDLE) && start;

  always_comb begin
    a_neg      = is_signed_a(op) & a[XLEN-1];
    b_neg      = is_signed_b(op) & b[XLEN-1];
    a_mag      = cond_neg(a, a_neg);
    b_mag      = cond_neg(b, b_neg);
    div_zero   = is_div(op) && (b == '0);
    div_ovf    = is_div(op) && is_signed_a(op) && (a == MIN_NEG) && (b == '1);
    special    = div_zero || div_ovf;
    // Remainder follows the dividend sign; product and quotient follow the XOR.
    launch_neg = (is_div(op) && op[1]) ? a_neg : (a_neg ^ b_neg);
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
  end

  muldiv_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_in  (acc),
    .opnd    (opnd),
    .div_mode(is_div(op_q)),
    .acc_out (acc_step)
  );

  always_comb begin
    prod    = cond_neg_wide(acc_step, neg_q);
    div_raw = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    if (is_div(op_q))         calc_res = cond_neg(div_raw, neg_q);
    else if (op_q == OP_MUL)  calc_res = prod[XLEN-1:0];
    else                      calc_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cnt <= special ? '0 : CNT_W'(N);
        if (special) result <= special_res;
      end else if (state == CALC) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) result <= calc_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      op_q  <= op;
      neg_q <= launch_neg;
      opnd  <= is_div(op) ? b_mag : a_mag;
      acc   <= {{XLEN{1'b0}}, (is_div(op) ? a_mag : b_mag)};
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against a plain-arithmetic
// model of the RISC-V M-extension results and the unit's cycle timing.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int N    = XLEN / BPC;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_m(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, uy_s, q;
    longint unsigned ux, uy, uq;
    logic [63:0]     p;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    uy_s = longint'({32'b0, y});
    p = '0;
    case (o)
      OP_MUL:    begin p = sx * sy;   return p[31:0];  end
      OP_MULH:   begin p = sx * sy;   return p[63:32]; end
      OP_MULHSU: begin p = sx * uy_s; return p[63:32]; end
      OP_MULHU:  begin p = ux * uy;   return p[63:32]; end
      OP_DIV, OP_REM: begin
        if (y == 0) return (o == OP_DIV) ? 32'hFFFF_FFFF : x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return (o == OP_DIV) ? x : 32'h0;
        q = (o == OP_DIV) ? (sx / sy) : (sx % sy);
        p = q;
        return p[31:0];
      end
      default: begin
        if (y == 0) return (o == OP_DIVU) ? 32'hFFFF_FFFF : x;
        uq = (o == OP_DIVU) ? (ux / uy) : (ux % uy);
        p = uq;
        return p[31:0];
      end
    endcase
  endfunction

  // Launch one operation from IDLE and follow it to the following IDLE cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    int   cyc, lat, exp_lat;
    bit   bad_busy, overlap, spec_case, exp_busy;
    spec_case = o[2] && (y == 0 || (o[0] == 1'b0 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    exp_lat   = spec_case ? 1 : N + 1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    cyc = 1; lat = 0; bad_busy = 0; overlap = 0;
    while (cyc <= N + 4) begin
      exp_busy = !spec_case && (cyc <= N);
      if (busy !== exp_busy) bad_busy = 1;
      if (busy && done) overlap = 1;
      if (done) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy window"}, {63'b0, bad_busy | overlap}, 64'd0);
    check({tag, " result"}, {32'b0, result}, {32'b0, exp});
    @(posedge clk); #1;
    check({tag, " idle after done"}, {62'b0, busy, done}, 64'd0);
    check({tag, " result held"}, {32'b0, result}, {32'b0, exp});
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y, exp;
    int n_done, bad_phase, bad_res, overlap, late_done;

    rst = 1'b1; start = 1'b0; op = OP_MUL; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset result", {32'b0, result}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh", OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhsu", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("mulhu", OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem -7%2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_op("remu 100%7", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_op("divu by zero", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem by zero", OP_REM, 32'd5, 32'd0, 32'd5);
    run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0:       y = '0;
        1:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2:       y = 32'($urandom_range(1, 15));
        3:       x = 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op("random", o, x, y, ref_m(o, x, y));
    end

    // start held high for 100 cycles: only IDLE cycles accept
    op = OP_MUL; a = 32'd7; b = 32'hFFFF_FFFD;
    exp = ref_m(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    n_done = 0; bad_phase = 0; bad_res = 0; overlap = 0;
    for (int c = 0; c < 100 + N + 2; c++) begin
      start = (c < 100);
      @(posedge clk); #1;
      if (busy && done) overlap++;
      if (done) begin
        n_done++;
        if (((c + 1) - (N + 1)) % (N + 2) != 0) bad_phase++;
        if (result !== exp) bad_res++;
      end
    end
    start = 1'b0;
    check("stream done count", 64'(n_done), 64'((100 + N + 1) / (N + 2)));
    check("stream done spacing", 64'(bad_phase), 64'd0);
    check("stream results", 64'(bad_res), 64'd0);
    check("stream busy/done overlap", 64'(overlap), 64'd0);

    // reset in the middle of a divide
    op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort done", {63'b0, done}, 64'd0);
    check("abort result", {32'b0, result}, 64'd0);
    rst = 1'b0;
    late_done = 0;
    for (int c = 0; c < N + 2; c++) begin
      if (done || busy) late_done++;
      @(posedge clk); #1;
    end
    check("abort no done pulse", 64'(late_done), 64'd0);
    run_op("mul after abort", OP_MUL, 32'd3, 32'd4, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide execution unit for the multicycle RISC-V core, implementing the full RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits in the datapath beside the ALU. The controller launches an operation with a start pulse carrying func3, then waits for the done pulse before writing the result back. It generalises the existing start/ctl/exdone multiplier path in three ways: configurable operand width, configurable bits retired per cycle, and full division support including RISC-V special cases.

## Interface

Parameters:
- XLEN, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, bits retired per iteration; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- op  in  3  func3 of the M instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand (multiplicand / dividend); sampled with start.
- b  in  XLEN  rs2 operand (multiplier / divisor); sampled with start.
- busy  out  1  high while an operation is in progress (CALC state).
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  XLEN  registered result; held until the next accepted start.

## Operation

- States: IDLE, CALC, DONE.
  - IDLE -> CALC on start. Operands, op, and magnitudes are latched. The iteration counter loads N = XLEN/BITS_PER_CYCLE.
  - IDLE -> DONE directly on start for the special cases: divide by zero and signed overflow.
  - CALC -> DONE when the counter reaches 0 after the last iteration. The result is sign-corrected and registered on that edge.
  - DONE -> IDLE unconditionally.
- start outside IDLE is ignored. The controller must hold start only in IDLE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Arithmetic is performed on XLEN-bit magnitudes, followed by conditional two's-complement negation of the result.
- Multiply: shift-add over a 2*XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU, MULHU return product[2*XLEN-1:XLEN].
  - The product is negated when exactly one of the signed-treated operands is negative.
- Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - The quotient is negated when the signed operand signs differ.
  - The remainder takes the sign of the dividend.
- Special cases, each with result ready in the cycle after start:
  - b = 0: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): DIV returns a; REM returns 0.
- Multiplication has no special cases and always iterates N cycles.

## Timing

- Reset: state IDLE, busy=0, done=0, result=0, counter=0.
- rst during CALC or DONE aborts the operation. The next cycle is IDLE with busy=0 and done=0. No done pulse is emitted for the aborted operation.
- Normal operation, with start sampled in cycle 0:
  - busy=1 in cycles 1..N.
  - done=1 and result valid in cycle N+1.
  - IDLE in cycle N+2, when a new start may be sampled.
  - Throughput is one operation per N+2 cycles.
- Special-case divide: done=1 in cycle 1 and busy stays 0. The next start is accepted in cycle 2.
- busy and done are never high in the same cycle.
- result changes only on the edge entering DONE (or on rst). It holds its value through IDLE.

## Structure

- Shared package muldiv_pkg holds:
  - the op encoding constants (OP_MUL .. OP_REMU, matching func3);
  - the state enum {IDLE, CALC, DONE};
  - helper functions is_div(op) and is_signed_a(op) / is_signed_b(op).
- Sub-module muldiv_step: a combinational single-iteration datapath, instantiated once.
  - Takes the accumulator, remainder/quotient registers, the operand magnitude, and the mode.
  - Returns the next values after BITS_PER_CYCLE steps via an internal generate loop.
  - muldiv_unit owns the FSM, counter, operand latches, special-case detection, and the final sign correction.

## Test plan

All cases use XLEN=32, BITS_PER_CYCLE=1 (N=32) unless noted.

- MUL a=7, b=-3 (0xFFFFFFFD): start at cycle 0 -> busy in cycles 1–32, done at cycle 33, result 0xFFFFFFEB. Repeat with BITS_PER_CYCLE=4 -> done at cycle 9.
- MULH, MULHSU, MULHU with a=0x80000000, b=0xFFFFFFFF -> results 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV a=-7, b=2 -> result 0xFFFFFFFD (-3). REM with the same operands -> result 0xFFFFFFFF (-1). DIVU a=100, b=7 -> result 14. REMU with the same operands -> result 2.
- DIVU a=5, b=0 -> done at cycle 1 with result 0xFFFFFFFF. REM a=5, b=0 -> result 5. DIV a=0x80000000, b=-1 -> done at cycle 1 with result 0x80000000. REM with the same operands -> result 0.
- Assert start on every cycle for 100 cycles -> operations are accepted only in IDLE, one done per N+2 cycles, and the busy/done invariant holds.
- Assert rst at cycle 10 of a DIV -> IDLE at cycle 11 with busy=0, no done pulse, result=0. A new MUL 3*4 started afterwards -> result 12.
